// File: rtl/fifo_pack_pkg.sv
// Shared widths and the word-FIFO entry layout for the byte-to-word packer.
package fifo_pack_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 32;
    localparam int BPW    = 4;
    localparam int MTY_W  = 2;

    typedef struct packed {
        logic [WORD_W-1:0] data;
        logic              sop;
        logic              eop;
        logic [MTY_W-1:0]  mty;
    } entry_t;

endpackage

// File: rtl/fifo_pack_if.sv
// Byte-in / word-out stream bundle; slave is the packer view, master the source/sink view.
interface fifo_pack_if;
    import fifo_pack_pkg::*;

    logic [BYTE_W-1:0] din;
    logic              din_vld;
    logic              din_sop;
    logic              din_eop;
    logic              din_rdy;
    logic [WORD_W-1:0] dout;
    logic              dout_vld;
    logic              dout_sop;
    logic              dout_eop;
    logic [MTY_W-1:0]  dout_mty;
    logic              b_rdy;
    logic              err;

    modport slave (
        input  din, din_vld, din_sop, din_eop, b_rdy,
        output din_rdy, dout, dout_vld, dout_sop, dout_eop, dout_mty, err
    );

    modport master (
        output din, din_vld, din_sop, din_eop, b_rdy,
        input  din_rdy, dout, dout_vld, dout_sop, dout_eop, dout_mty, err
    );

endinterface

// File: rtl/fifo_pack_wfifo.sv
// First-word-fall-through entry FIFO; head reads as zero while empty.
module fifo_pack_wfifo
    import fifo_pack_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  entry_t        wdata,
    input  logic          pop,
    output entry_t        rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    entry_t        mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/fifo_pack.sv
// Packs a byte stream big-endian into 32-bit words with sop/eop/mty flags.
// Define FIFO_PACK_ERR_CHK_EN to enable sop protocol checking and the err pulse.
module fifo_pack
    import fifo_pack_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input logic        clk,
    input logic        rst,
    fifo_pack_if.slave bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [1:0]        cnt_q, cnt_d, base_cnt;
    logic [WORD_W-1:0] asm_q, asm_d, base_asm, word;
    logic              sop_q, sop_d, base_sop;
    logic              accept, keep, cur_sop, last, push;
    entry_t            wentry, head;
    logic              wfull, wempty;
    logic [CW-1:0]     wcount;

`ifdef FIFO_PACK_ERR_CHK_EN
    logic in_pkt_q, in_pkt_d;
    logic err_q, err_d;
`endif

    assign accept = bus.din_vld & bus.din_rdy;

    always_comb begin
        keep     = 1'b1;
        base_cnt = cnt_q;
        base_asm = asm_q;
        base_sop = sop_q;
`ifdef FIFO_PACK_ERR_CHK_EN
        err_d    = 1'b0;
        in_pkt_d = in_pkt_q;
        if (accept) begin
            if (!in_pkt_q && !bus.din_sop) begin
                keep  = 1'b0;
                err_d = 1'b1;
            end else if (in_pkt_q && bus.din_sop) begin
                // Restart: drop the partial word and begin at byte 0.
                err_d    = 1'b1;
                base_cnt = '0;
                base_asm = '0;
                base_sop = 1'b0;
            end
            if (keep) in_pkt_d = ~bus.din_eop;
        end
`endif
        word = base_asm;
        word[(2'd3 - base_cnt) * BYTE_W +: BYTE_W] = bus.din;
        cur_sop = base_sop | bus.din_sop;
        last    = (base_cnt == 2'd3) | bus.din_eop;
        cnt_d   = cnt_q;
        asm_d   = asm_q;
        sop_d   = sop_q;
        push    = 1'b0;
        wentry  = '0;
        if (accept && keep) begin
            if (last) begin
                push        = 1'b1;
                wentry.data = word;
                wentry.sop  = cur_sop;
                wentry.eop  = bus.din_eop;
                wentry.mty  = bus.din_eop ? (2'd3 - base_cnt) : 2'd0;
                cnt_d       = '0;
                asm_d       = '0;
                sop_d       = 1'b0;
            end else begin
                cnt_d = base_cnt + 2'd1;
                asm_d = word;
                sop_d = cur_sop;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            asm_q <= '0;
            sop_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            asm_q <= asm_d;
            sop_q <= sop_d;
        end
    end

`ifdef FIFO_PACK_ERR_CHK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_pkt_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            in_pkt_q <= in_pkt_d;
            err_q    <= err_d;
        end
    end
    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    fifo_pack_wfifo #(.DEPTH(DEPTH)) u_wfifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push & ~wfull),
        .wdata (wentry),
        .pop   (bus.b_rdy),
        .rdata (head),
        .full  (wfull),
        .empty (wempty),
        .count (wcount)
    );

    // Ready depends only on the registered count, never on b_rdy.
    assign bus.din_rdy  = ~rst & (wcount != CW'(DEPTH));
    assign bus.dout_vld = ~wempty;
    assign bus.dout     = head.data;
    assign bus.dout_sop = head.sop;
    assign bus.dout_eop = head.eop;
    assign bus.dout_mty = head.mty;

endmodule

// File: doc/fifo_pack.md
FIFO_PACK -- requirements
Module: fifo_pack

Interface
REQ-001 SHALL have parameter DEPTH, default 8, word-FIFO depth in 36-bit entries (power of two, min 2).
REQ-002 SHALL have port clk  input  1  single clock, all logic rising-edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port din  input  8  packet byte.
REQ-005 SHALL have port din_vld  input  1  din qualifier.
REQ-006 SHALL have port din_sop  input  1  first byte of packet.
REQ-007 SHALL have port din_eop  input  1  last byte of packet.
REQ-008 SHALL have port din_rdy  output  1  byte accepted when din_vld && din_rdy.
REQ-009 SHALL have port dout  output  32  packed word, first byte in [31:24].
REQ-010 SHALL have port dout_vld  output  1  dout qualifier.
REQ-011 SHALL have port dout_sop  output  1  first word of packet.
REQ-012 SHALL have port dout_eop  output  1  last word of packet.
REQ-013 SHALL have port dout_mty  output  2  empty low-order bytes in eop word, else 0.
REQ-014 SHALL have port b_rdy  input  1  downstream ready; word consumed when dout_vld && b_rdy.
REQ-015 SHALL have port err  output  1  one-cycle protocol-error pulse.

Function
REQ-016 SHALL pack accepted bytes big-endian into a 4-byte assembly register indexed by a 2-bit byte counter.
REQ-017 SHALL push {word, sop, eop, mty} into the word FIFO on the same edge the 4th byte, or an eop byte, is accepted; counter then returns to 0.
REQ-018 SHALL set mty = 3 - counter on eop push, and SHALL zero unfilled low bytes.
REQ-019 SHALL set entry sop when the word holds the packet's sop byte.
REQ-020 SHALL drive din_rdy = word FIFO not full, registered-count based, with no combinational path from b_rdy.
REQ-021 SHALL present the FIFO head first-word-fall-through; dout_vld = FIFO not empty; latency from the completing byte's accept edge to dout_vld is one cycle when the FIFO was empty.
REQ-022 SHALL hold dout/flags stable while dout_vld && !b_rdy.
REQ-023 SHALL allow simultaneous push and pop with count unchanged; when full, no push occurs that cycle even if b_rdy=1.
REQ-024 SHALL treat a byte with din_sop && din_eop as a one-byte packet (mty=3, sop=eop=1).

Reset
REQ-025 SHALL, on rst assertion, immediately clear counter, in-packet flag, FIFO pointers and count; outputs dout=0, dout_vld=0, dout_sop=0, dout_eop=0, dout_mty=0, err=0, din_rdy=0 during reset, 1 in the first cycle after release.
REQ-026 SHALL discard partial and stored words on reset mid-packet; no residual word after release.

Configuration
REQ-027 SHALL support macro FIFO_PACK_ERR_CHK_EN.
REQ-028 With FIFO_PACK_ERR_CHK_EN: byte without din_sop outside a packet is accepted and dropped with err pulse; din_sop inside a packet discards partial assembly bytes, pulses err, starts the new packet at byte 0.
REQ-029 Without FIFO_PACK_ERR_CHK_EN: no checking, err tied 0, din_sop only marks entry sop.

Structure
REQ-030 SHALL place BYTE_W=8, WORD_W=32, BPW=4, MTY_W=2 and the FIFO entry struct (data, sop, eop, mty) in package fifo_pack_pkg.
REQ-031 SHALL instantiate sub-module fifo_pack_wfifo: synchronous FWFT FIFO of DEPTH entries with full/empty/count.

Verification
REQ-032 40 bytes 0x00..0x27, sop on first, eop on last, b_rdy=1 -> 10 words 0x00010203..0x24252627; sop on first, eop on last, mty=0.
REQ-033 6-byte packet 0x00..0x05 -> words 0x00010203 (sop) then 0x04050000 (eop, mty=2).
REQ-034 b_rdy=0, 40-byte packet, DEPTH=8 -> din_rdy falls after 32 bytes accepted; b_rdy=1 later -> all 10 words in order, no loss or duplication.
REQ-035 rst pulsed after 5 bytes of a packet -> dout_vld=0 immediately; next 4-byte packet yields single word with sop=eop=1, mty=0.
REQ-036 With FIFO_PACK_ERR_CHK_EN: 2 bytes 0xAA,0xBB (sop on 0xAA) then sop on 0x01..0x04 with eop -> err one pulse, only word 0x01020304 (sop, eop) emitted.
